hwpe_stream_upsizer: RTL and testbench

- Width-conversion stage that sits directly downstream of hwpe_stream_fifo's pop side.
- Consumes a narrow HWPE stream of IN_WIDTH bits and packs RATIO consecutive beats into one wide beat of IN_WIDTH*RATIO bits, with matching strobes.
- Feeds wide consumers such as streamers and TCDM-wide sinks.
- Full throughput: one narrow beat accepted per cycle, including while a completed wide word waits for its consumer.

---
 rtl/hwpe_stream_upsizer.sv | 143 ++++++++++++++
 tb/tb_hwpe_stream_upsizer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_upsizer.sv
// Packs RATIO narrow HWPE stream beats into one wide beat (lane 0 = LSBs).
// Optional partial-word flush port enabled by HWPE_STREAM_UPSIZER_FLUSH_EN.
module hwpe_stream_upsizer #(
  parameter int unsigned IN_WIDTH = 32,
  parameter int unsigned RATIO    = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
`ifdef HWPE_STREAM_UPSIZER_FLUSH_EN
  input  logic                           flush_i,
`endif
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [IN_WIDTH-1:0]            in_data_i,
  input  logic [IN_WIDTH/8-1:0]          in_strb_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [IN_WIDTH*RATIO-1:0]      out_data_o,
  output logic [IN_WIDTH*RATIO/8-1:0]    out_strb_o,
  output logic [$clog2(RATIO)-1:0]       lane_cnt_o
);

  localparam int unsigned STRB_W      = IN_WIDTH / 8;
  localparam int unsigned OUT_WIDTH   = IN_WIDTH * RATIO;
  localparam int unsigned OUT_STRB_W  = OUT_WIDTH / 8;
  localparam int unsigned CNT_W       = $clog2(RATIO);
  localparam int unsigned LANE_W      = (RATIO - 1) * IN_WIDTH;
  localparam int unsigned LANE_STRB_W = (RATIO - 1) * STRB_W;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  logic [LANE_W-1:0]      lane_data_p0;
  logic [LANE_STRB_W-1:0] lane_strb_p0;
  logic [CNT_W-1:0]       cnt_p0;
  logic                   vld_p1;
  logic [OUT_WIDTH-1:0]   out_data_p1;
  logic [OUT_STRB_W-1:0]  out_strb_p1;

  logic last_lane;
  logic out_free;
  logic in_hs;
  logic out_hs;
  logic load_full;

  assign last_lane = (cnt_p0 == LAST_LANE);
  assign out_free  = !vld_p1 || out_ready_i;
  assign in_hs     = in_valid_i && in_ready_o;
  assign out_hs    = vld_p1 && out_ready_i;
  assign load_full = in_hs && last_lane;

`ifdef HWPE_STREAM_UPSIZER_FLUSH_EN
  logic                  flush_pending_p0;
  logic                  flush_fire;
  logic                  flush_emit;
  logic [OUT_WIDTH-1:0]  part_data;
  logic [OUT_STRB_W-1:0] part_strb;

  assign flush_fire = flush_pending_p0 && out_free;
  assign flush_emit = flush_fire && (cnt_p0 != '0);
  // Only the cnt lanes filled so far survive; the rest read as zero data/strobes.
  always_comb begin
    part_data = '0;
    part_strb = '0;
    for (int k = 0; k < int'(RATIO) - 1; k++) begin
      if (CNT_W'(k) < cnt_p0) begin
        part_data[k*IN_WIDTH +: IN_WIDTH] = lane_data_p0[k*IN_WIDTH +: IN_WIDTH];
        part_strb[k*STRB_W +: STRB_W]     = lane_strb_p0[k*STRB_W +: STRB_W];
      end
    end
  end

  assign in_ready_o = !flush_pending_p0 && (!last_lane || out_free);
`else
  assign in_ready_o = !last_lane || out_free;
`endif

  // Stage p0: lane staging and counter; stage p1: wide output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_data_p0 <= '0;
      lane_strb_p0 <= '0;
      cnt_p0       <= '0;
      vld_p1       <= 1'b0;
      out_data_p1  <= '0;
      out_strb_p1  <= '0;
`ifdef HWPE_STREAM_UPSIZER_FLUSH_EN
      flush_pending_p0 <= 1'b0;
`endif
    end else if (clear_i) begin
      lane_data_p0 <= '0;
      lane_strb_p0 <= '0;
      cnt_p0       <= '0;
      vld_p1       <= 1'b0;
      out_data_p1  <= '0;
      out_strb_p1  <= '0;
`ifdef HWPE_STREAM_UPSIZER_FLUSH_EN
      flush_pending_p0 <= 1'b0;
`endif
    end else begin
      if (in_hs) begin
        if (last_lane) begin
          cnt_p0 <= '0;
        end else begin
          cnt_p0 <= cnt_p0 + 1'b1;
          for (int k = 0; k < int'(RATIO) - 1; k++) begin
            if (cnt_p0 == CNT_W'(k)) begin
              lane_data_p0[k*IN_WIDTH +: IN_WIDTH] <= in_data_i;
              lane_strb_p0[k*STRB_W +: STRB_W]     <= in_strb_i;
            end
          end
        end
      end
`ifdef HWPE_STREAM_UPSIZER_FLUSH_EN
      // A beat accepted alongside flush_i is staged first; the flush acts next cycle.
      flush_pending_p0 <= flush_i || (flush_pending_p0 && !out_free);
      if (flush_fire) begin
        cnt_p0 <= '0;
      end
`endif
      if (load_full) begin
        vld_p1      <= 1'b1;
        out_data_p1 <= {in_data_i, lane_data_p0};
        out_strb_p1 <= {in_strb_i, lane_strb_p0};
      end
`ifdef HWPE_STREAM_UPSIZER_FLUSH_EN
      else if (flush_emit) begin
        vld_p1      <= 1'b1;
        out_data_p1 <= part_data;
        out_strb_p1 <= part_strb;
      end
`endif
      else if (out_hs) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid_o = vld_p1;
  assign out_data_o  = out_data_p1;
  assign out_strb_o  = out_strb_p1;
  assign lane_cnt_o  = cnt_p0;

endmodule

// File: tb/tb_hwpe_stream_upsizer.sv
// Bench for hwpe_stream_upsizer (IN_WIDTH=32, RATIO=4): table vectors plus
// hand sequences, with a queue of expected wide words checked at each out handshake.
module tb_hwpe_stream_upsizer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic [3:0]   in_strb = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [15:0]  out_strb;
  logic [1:0]   lane_cnt;
`ifdef HWPE_STREAM_UPSIZER_FLUSH_EN
  logic         flush = 1'b0;
`endif

  hwpe_stream_upsizer #(.IN_WIDTH(32), .RATIO(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
`ifdef HWPE_STREAM_UPSIZER_FLUSH_EN
    .flush_i     (flush),
`endif
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_strb_i   (in_strb),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_strb_o  (out_strb),
    .lane_cnt_o  (lane_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [15:0]  s;
  } exp_t;

  typedef struct {
    logic [3:0][31:0] d;
    logic [3:0][3:0]  s;
    logic [127:0]     ed;
    logic [15:0]      es;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t tbl[4];
  int   errors = 0;
  int   checks = 0;
  int   words = 0;
  int   cyc = 0;
  bit   stream_on = 1'b0;
  int   hs_cyc[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [127:0] d, input logic [15:0] s);
    exp_t e;
    e.d = d;
    e.s = s;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the beat's handshake edge.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_strb  = s;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", 128'(exp_q.size()), 128'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // A word counts as delivered when valid&ready are seen mid-cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      words++;
      if (stream_on) hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h expected none", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("word_data", out_data, mon_e.d);
        chk("word_strb", 128'(out_strb), 128'(mon_e.s));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] w, w1, w2;
    logic [31:0]  d;
    int           c0, c1, w0;

    tbl[0].d  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    tbl[0].s  = {4'hF, 4'hF, 4'hF, 4'hF};
    tbl[0].ed = 128'h44444444_33333333_22222222_11111111;
    tbl[0].es = 16'hFFFF;
    tbl[1].d  = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    tbl[1].s  = {4'h8, 4'hF, 4'h0, 4'h1};
    tbl[1].ed = 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0;
    tbl[1].es = 16'h8F01;
    tbl[2].d  = {32'h01234567, 32'hFFFFFFFF, 32'h00000000, 32'hDEADBEEF};
    tbl[2].s  = {4'hF, 4'hF, 4'hF, 4'hF};
    tbl[2].ed = 128'h01234567_FFFFFFFF_00000000_DEADBEEF;
    tbl[2].es = 16'hFFFF;
    tbl[3].d  = {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001};
    tbl[3].s  = {4'h9, 4'h6, 4'hC, 4'h3};
    tbl[3].ed = 128'h00000004_00000003_00000002_00000001;
    tbl[3].es = 16'h96C3;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_out_strb", 128'(out_strb), 128'd0);
    chk("rst_lane_cnt", 128'(lane_cnt), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);

    // Table vectors: packing, strobe pass-through, 1-cycle latency, 1-cycle valid.
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      push_exp(tbl[v].ed, tbl[v].es);
      for (int b = 0; b < 4; b++) send_beat(tbl[v].d[b], tbl[v].s[b]);
      chk($sformatf("vec%0d_valid", v), 128'(out_valid), 128'd1);
      chk($sformatf("vec%0d_data", v), out_data, tbl[v].ed);
      chk($sformatf("vec%0d_strb", v), 128'(out_strb), 128'(tbl[v].es));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid_drop", v), 128'(out_valid), 128'd0);
    end

    // Back-pressure: 7 beats accepted, the 8th stalls, then back-to-back reload.
    out_ready = 1'b0;
    w1 = '0;
    w2 = '0;
    for (int i = 0; i < 4; i++) w1[i*32 +: 32] = 32'hB0000000 + i;
    for (int i = 0; i < 4; i++) w2[i*32 +: 32] = 32'hB0000004 + i;
    push_exp(w1, 16'hFFFF);
    push_exp(w2, 16'hFFFF);
    for (int i = 0; i < 7; i++) send_beat(32'hB0000000 + i, 4'hF);
    chk("bp_lane_cnt", 128'(lane_cnt), 128'd3);
    chk("bp_valid", 128'(out_valid), 128'd1);
    chk("bp_data", out_data, w1);
    in_valid = 1'b1;
    in_data  = 32'hB0000007;
    in_strb  = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_hold_data", out_data, w1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_nobubble_valid", 128'(out_valid), 128'd1);
    chk("bp_nobubble_data", out_data, w2);
    chk("bp_lane_cnt_after", 128'(lane_cnt), 128'd0);
    wait_drain();

    // Streaming: 40 beats, one per cycle, 10 words spaced exactly 4 cycles apart.
    stream_on = 1'b1;
    w = '0;
    c0 = cyc;
    for (int i = 0; i < 40; i++) begin
      d = 32'hC0DE0000 + i * 32'h00010001;
      w[(i % 4) * 32 +: 32] = d;
      if (i % 4 == 3) push_exp(w, 16'hFFFF);
      send_beat(d, 4'hF);
    end
    c1 = cyc;
    chk("stream_cycles", 128'(c1 - c0), 128'd40);
    wait_drain();
    stream_on = 1'b0;
    chk("stream_words", 128'(hs_cyc.size()), 128'd10);
    for (int k = 1; k < hs_cyc.size(); k++)
      chk($sformatf("stream_gap%0d", k), 128'(hs_cyc[k] - hs_cyc[k-1]), 128'd4);

    // Clear mid-group discards the partial group and the beat offered with it.
    w0 = words;
    send_beat(32'hEEEE0001, 4'hF);
    send_beat(32'hEEEE0002, 4'hF);
    in_valid = 1'b1;
    in_data  = 32'hEEEE0003;
    in_strb  = 4'hF;
    clear    = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_lane_cnt", 128'(lane_cnt), 128'd0);
    chk("clr_valid", 128'(out_valid), 128'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("clr_no_word", 128'(words), 128'(w0));
    push_exp(128'h00000054_00000053_00000052_00000051, 16'h3F1F);
    send_beat(32'h00000051, 4'hF);
    send_beat(32'h00000052, 4'h1);
    send_beat(32'h00000053, 4'hF);
    send_beat(32'h00000054, 4'h3);
    wait_drain();
    chk("clr_after_lane_cnt", 128'(lane_cnt), 128'd0);

    // Asynchronous reset mid-group drops the partial group immediately.
    send_beat(32'h77770001, 4'hF);
    send_beat(32'h77770002, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_lane_cnt", 128'(lane_cnt), 128'd0);
    chk("arst_valid", 128'(out_valid), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp(128'h88880004_88880003_88880002_88880001, 16'hFFFF);
    for (int i = 1; i <= 4; i++) send_beat(32'h88880000 + i, 4'hF);
    wait_drain();

`ifdef HWPE_STREAM_UPSIZER_FLUSH_EN
    // Partial flush emits lanes 0..2 with the top lane zeroed.
    push_exp(128'h00000000_0000000C_0000000B_0000000A, 16'h0FFF);
    send_beat(32'h0000000A, 4'hF);
    send_beat(32'h0000000B, 4'hF);
    send_beat(32'h0000000C, 4'hF);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready", 128'(in_ready), 128'd0);
    wait_drain();
    chk("flush_lane_cnt", 128'(lane_cnt), 128'd0);
    w0 = words;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("flush_empty_no_word", 128'(words), 128'(w0));
    chk("flush_empty_in_ready", 128'(in_ready), 128'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
